// File: rtl/hex_digit_counter_if.sv
// hex_digit_counter_if: control/status bundle between the switch/key logic and
// the hex digit counter.
//   enable, rate_sel, up, load, load_value : control into the counter
//   digit0, digit1                         : low/high hex digits to the decoders
//   tick, carry                            : one-cycle step / wrap status pulses
// Modports: master drives control and observes status; slave is the counter.
interface hex_digit_counter_if;
    logic       enable;
    logic [1:0] rate_sel;
    logic       up;
    logic       load;
    logic [7:0] load_value;
    logic [3:0] digit0;
    logic [3:0] digit1;
    logic       tick;
    logic       carry;

    modport master (
        output enable, rate_sel, up, load, load_value,
        input  digit0, digit1, tick, carry
    );

    modport slave (
        input  enable, rate_sel, up, load, load_value,
        output digit0, digit1, tick, carry
    );
endinterface

// File: rtl/hex_digit_counter.sv
// hex_digit_counter: rate-divided 8-bit up/down counter feeding two hex digit
// decoders, with parallel load and one-cycle tick/carry status pulses.
// Ports:
//   clock - system clock, rising edge
//   reset - synchronous active-high reset
//   bus   - hex_digit_counter_if.slave (control in, digits and pulses out)
// Parameters:
//   CLK_FREQ - clock cycles per second; divider reloads derive from it
//   DIV_W    - divider width, must hold 4*CLK_FREQ-1
// Build option: define COUNT_SAT_EN to saturate at 0xFF (up) / 0x00 (down)
// instead of wrapping; saturated steps still reload the divider but raise no
// tick or carry.
module hex_digit_counter #(
    parameter int unsigned CLK_FREQ = 50000000,
    parameter int unsigned DIV_W    = 28
) (
    input logic               clock,
    input logic               reset,
    hex_digit_counter_if.slave bus
);

    localparam logic [DIV_W-1:0] Reload1 = DIV_W'(CLK_FREQ - 1);
    localparam logic [DIV_W-1:0] Reload2 = DIV_W'(2 * CLK_FREQ - 1);
    localparam logic [DIV_W-1:0] Reload4 = DIV_W'(4 * CLK_FREQ - 1);

    logic [7:0]       count_q, count_d;
    logic [DIV_W-1:0] div_q, div_d;
    logic             tick_q, tick_d;
    logic             carry_q, carry_d;

    logic [DIV_W-1:0] reload;
    logic [7:0]       stepped;
    logic             at_limit;

    // Reload follows the live rate_sel, so a rate change only takes effect at
    // the next reload rather than restarting the current period.
    always_comb begin
        unique case (bus.rate_sel)
            2'b00: reload = '0;
            2'b01: reload = Reload1;
            2'b10: reload = Reload2;
            2'b11: reload = Reload4;
        endcase
    end

    assign stepped  = bus.up ? count_q + 8'd1 : count_q - 8'd1;
    assign at_limit = bus.up ? (count_q == 8'hff) : (count_q == 8'h00);

    always_comb begin
        count_d = count_q;
        div_d   = div_q;
        tick_d  = 1'b0;
        carry_d = 1'b0;
        if (bus.load) begin
            count_d = bus.load_value;
            div_d   = reload;
        end else if (bus.enable) begin
            if (div_q == '0) begin
                div_d = reload;
`ifdef COUNT_SAT_EN
                if (!at_limit) begin
                    count_d = stepped;
                    tick_d  = 1'b1;
                end
`else
                count_d = stepped;
                tick_d  = 1'b1;
                carry_d = at_limit;
`endif
            end else begin
                div_d = div_q - 1'b1;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            count_q <= 8'h00;
            div_q   <= reload;
            tick_q  <= 1'b0;
            carry_q <= 1'b0;
        end else begin
            count_q <= count_d;
            div_q   <= div_d;
            tick_q  <= tick_d;
            carry_q <= carry_d;
        end
    end

    assign bus.digit0 = count_q[3:0];
    assign bus.digit1 = count_q[7:4];
    assign bus.tick   = tick_q;
    assign bus.carry  = carry_q;

endmodule

// File: tb/tb_hex_digit_counter.sv
// tb_hex_digit_counter: directed self-checking bench for hex_digit_counter
// with CLK_FREQ=4 (rate 01 period 4, rate 11 period 16).
module tb_hex_digit_counter;

    logic clock;
    logic reset;
    int   n_checks;
    int   n_pass;

    hex_digit_counter_if bus ();

    hex_digit_counter #(
        .CLK_FREQ(4),
        .DIV_W   (8)
    ) dut (
        .clock(clock),
        .reset(reset),
        .bus  (bus)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string tag, input int unsigned obs, input int unsigned exp);
        n_checks++;
        if (obs == exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    endtask

    // Advance n rising edges; sample and drive 1 time unit after the edge.
    task automatic cycles(input int n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    function automatic int unsigned cnt();
        return {bus.digit1, bus.digit0};
    endfunction

    initial begin
        n_checks       = 0;
        n_pass         = 0;
        reset          = 1'b1;
        bus.enable     = 1'b1;
        bus.rate_sel   = 2'b01;
        bus.up         = 1'b1;
        bus.load       = 1'b0;
        bus.load_value = 8'h00;
        cycles(2);
        check("reset count", cnt(), 8'h00);
        check("reset tick", bus.tick, 0);
        check("reset carry", bus.carry, 0);

        // Rate 01: steps every 4 enabled cycles.
        reset = 1'b0;
        cycles(3);
        check("r01 pre-step count", cnt(), 8'h00);
        check("r01 pre-step tick", bus.tick, 0);
        cycles(1);
        check("r01 step1 count", cnt(), 8'h01);
        check("r01 step1 tick", bus.tick, 1);
        cycles(1);
        check("r01 tick one cycle", bus.tick, 0);
        cycles(3);
        check("r01 digit0 after 8", bus.digit0, 4'h2);
        check("r01 digit1 after 8", bus.digit1, 4'h0);
        check("r01 step2 tick", bus.tick, 1);

        // Load FE at rate 00, count up through the wrap.
        bus.rate_sel   = 2'b00;
        bus.load       = 1'b1;
        bus.load_value = 8'hfe;
        cycles(1);
        bus.load = 1'b0;
        check("load FE count", cnt(), 8'hfe);
        check("load FE no tick", bus.tick, 0);
        cycles(1);
        check("up FF count", cnt(), 8'hff);
        check("up FF carry", bus.carry, 0);
        cycles(1);
`ifdef COUNT_SAT_EN
        check("sat up hold", cnt(), 8'hff);
        check("sat up tick", bus.tick, 0);
        check("sat up carry", bus.carry, 0);
`else
        check("wrap up count", cnt(), 8'h00);
        check("wrap up tick", bus.tick, 1);
        check("wrap up carry", bus.carry, 1);
        cycles(1);
        check("up 01 count", cnt(), 8'h01);
        check("up 01 carry cleared", bus.carry, 0);
`endif

        // Load 00 and count down at rate 00.
        bus.load       = 1'b1;
        bus.load_value = 8'h00;
        bus.up         = 1'b0;
        cycles(1);
        bus.load = 1'b0;
        check("load 00 count", cnt(), 8'h00);
        cycles(1);
`ifdef COUNT_SAT_EN
        check("sat down hold", cnt(), 8'h00);
        check("sat down carry", bus.carry, 0);
`else
        check("wrap down digit1", bus.digit1, 4'hf);
        check("wrap down digit0", bus.digit0, 4'hf);
        check("wrap down carry", bus.carry, 1);
        cycles(1);
        check("down FE count", cnt(), 8'hfe);
        check("down FE carry", bus.carry, 0);
`endif

        // Rate 11 with enable dropped for 10 cycles mid-period.
        bus.rate_sel   = 2'b11;
        bus.up         = 1'b1;
        bus.load       = 1'b1;
        bus.load_value = 8'h00;
        cycles(1);
        bus.load = 1'b0;
        cycles(5);
        bus.enable = 1'b0;
        cycles(10);
        check("frozen count", cnt(), 8'h00);
        check("frozen tick", bus.tick, 0);
        bus.enable = 1'b1;
        cycles(10);
        check("r11 before step", cnt(), 8'h00);
        cycles(1);
        check("r11 step count", cnt(), 8'h01);
        check("r11 step tick", bus.tick, 1);

        // Reset 2 cycles into a rate 01 period with count 0x37.
        bus.rate_sel   = 2'b01;
        bus.load       = 1'b1;
        bus.load_value = 8'h37;
        cycles(1);
        bus.load = 1'b0;
        check("load 37 count", cnt(), 8'h37);
        cycles(2);
        reset = 1'b1;
        cycles(1);
        reset = 1'b0;
        check("mid reset count", cnt(), 8'h00);
        check("mid reset tick", bus.tick, 0);
        check("mid reset carry", bus.carry, 0);
        cycles(3);
        check("post reset pre-step", cnt(), 8'h00);
        cycles(1);
        check("post reset step", cnt(), 8'h01);

        // Reset beats load; load alone then applies with no tick.
        reset          = 1'b1;
        bus.load       = 1'b1;
        bus.load_value = 8'ha5;
        cycles(1);
        reset = 1'b0;
        check("reset over load", cnt(), 8'h00);
        cycles(1);
        bus.load   = 1'b0;
        bus.enable = 1'b0;
        check("load A5 count", cnt(), 8'ha5);
        check("load A5 no tick", bus.tick, 0);
        check("load A5 no carry", bus.carry, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
